mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: BEATS, 4, read-response beats per read request (one 512-bit line as 4 x 128-bit beats).
REQ-002 Parameter: ADDR_BITS, 28, memory line-beat address width (word address [29:2]).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 Ports prefixed ic_ (instruction cache) and dc_ (data cache) are requesters; ports prefixed mem_ face memory. Each signal line below applies to all three prefixes; direction is given as requester/mem.
REQ-006 *_req_valid  in/out  1  request valid.
REQ-007 *_req_ready  out/in  1  request accepted.
REQ-008 *_req_addr  in/out  ADDR_BITS  beat address.
REQ-009 *_req_rw  in/out  1  1 = write, 0 = read.
REQ-010 *_req_data_valid  in/out  1  write data valid.
REQ-011 *_req_data_ready  out/in  1  write data accepted.
REQ-012 *_req_data_bits  in/out  `MEM_DATA_BITS  write data.
REQ-013 *_req_data_mask  in/out  `MEM_DATA_BITS/8  byte mask.
REQ-014 *_resp_valid  out/in  1  read beat valid.
REQ-015 *_resp_data  out/in  `MEM_DATA_BITS  read beat data.

Function
REQ-016 States: IDLE, REQ, WDATA, RRESP; registered owner bit (0 = ic, 1 = dc).
REQ-017 IDLE: no mem_ outputs asserted; if any *_req_valid, latch owner via round-robin and go to REQ next cycle (1-cycle arbitration latency).
REQ-018 Round-robin: a single requester wins; if both request, the one not granted last wins; after reset dc wins the first tie.
REQ-019 REQ/WDATA: mem_req_valid, addr, rw, data_valid, data_bits and data_mask are the owner's inputs passed through combinationally; mem_req_data_valid is forced low when rw = 0.
REQ-020 Owner's *_req_ready and *_req_data_ready mirror mem_ readies; non-owner's readies are always 0.
REQ-021 REQ, read handshake (valid and ready): go to RRESP with beat counter = 0.
REQ-022 REQ, write handshake: go to IDLE if the data handshake has completed (this cycle or earlier, via a data_done flag); otherwise go to WDATA.
REQ-023 WDATA: mem_req_valid = 0; on data handshake go to IDLE.
REQ-024 REQ with the owner's req_valid low before any handshake: abandon and return to IDLE; the grant pointer still advances.
REQ-025 RRESP: mem_resp_valid routes to the owner's *_resp_valid only; *_resp_data is mem_resp_data broadcast to both requesters.
REQ-026 The beat counter is clog2(BEATS) wide and increments per beat; on beat BEATS-1, go to IDLE and clear the counter.
REQ-027 mem_resp_valid outside RRESP is dropped; no *_resp_valid is asserted.
REQ-028 Back-to-back transactions: the next grant is decided in the IDLE cycle following completion, giving a minimum of 1 bubble cycle.
REQ-029 The owner does not change while state != IDLE, regardless of requester activity.

Reset
REQ-030 Asserting reset at any time, including mid-transaction, forces state IDLE, owner 0, pointer such that dc wins the first tie, counter 0, data_done 0.
REQ-031 During reset, all outputs are 0; the in-flight transaction is abandoned and its late responses are dropped per REQ-027.

Structure
REQ-032 State encodings and BEATS default live in const.vh; MEM_DATA_BITS is taken from const.vh.
REQ-033 One sub-module, rr_arb2: a 2-input round-robin arbiter with an update enable, instantiated once.

Verification
REQ-034 Single ic read at addr 0x0000040: REQ 1 cycle after valid; 4 mem_resp beats 0xA0..0xA3 appear on ic_resp only; dc_resp_valid stays 0; IDLE after 4th beat.
REQ-035 ic and dc request simultaneously after reset: dc granted first; ic granted on the next IDLE; then a further tie goes to dc.
REQ-036 dc write with data handshake 2 cycles after req handshake: passes through WDATA; mask 0xFFFF and data passed unchanged; no resp routed.
REQ-037 dc write with req and data handshaking in the same cycle: REQ -> IDLE directly, no WDATA cycle.
REQ-038 reset asserted after beat 2 of a read: outputs 0 immediately; beats 3-4 arriving later produce no *_resp_valid.
REQ-039 Stray mem_resp_valid in IDLE and ic req_valid dropped in REQ: nothing routed, return to IDLE, pointer advances.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-requester memory arbiter: data widths,
// default burst length and FSM state encodings.
package mem_arbiter_pkg;
  localparam int MEM_DATA_BITS = 128;
  localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;
  localparam int BEATS_DEF     = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WDATA = 2'd2;
  localparam logic [1:0] S_RRESP = 2'd3;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. On a tie the input not granted last wins;
// out of reset the pointer favours input 1.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt,
  output logic       any
);
  logic last;

  assign any = |req;

  always_comb begin
    if (&req) gnt = ~last;
    else      gnt = req[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          last <= 1'b0;
    else if (en && any)  last <= gnt;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction and data caches onto one memory port. A grant is
// held for a whole request/write-data/read-burst transaction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BEATS     = BEATS_DEF,
  parameter int ADDR_BITS = 28
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     ic_req_valid,
  output logic                     ic_req_ready,
  input  logic [ADDR_BITS-1:0]     ic_req_addr,
  input  logic                     ic_req_rw,
  input  logic                     ic_req_data_valid,
  output logic                     ic_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] ic_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] ic_req_data_mask,
  output logic                     ic_resp_valid,
  output logic [MEM_DATA_BITS-1:0] ic_resp_data,

  input  logic                     dc_req_valid,
  output logic                     dc_req_ready,
  input  logic [ADDR_BITS-1:0]     dc_req_addr,
  input  logic                     dc_req_rw,
  input  logic                     dc_req_data_valid,
  output logic                     dc_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] dc_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] dc_req_data_mask,
  output logic                     dc_resp_valid,
  output logic [MEM_DATA_BITS-1:0] dc_resp_data,

  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_BITS-1:0]     mem_req_addr,
  output logic                     mem_req_rw,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
  output logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
  input  logic                     mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_resp_data
);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [1:0]     state;
  logic           owner;
  logic [CW-1:0]  cnt;
  logic           data_done;

  // Index 0 = ic, index 1 = dc, matching the owner bit.
  logic [1:0]                          r_valid, r_rw, r_dvalid;
  logic [1:0][ADDR_BITS-1:0]           r_addr;
  logic [1:0][MEM_DATA_BITS-1:0]       r_bits;
  logic [1:0][MEM_MASK_BITS-1:0]       r_mask;

  assign r_valid  = {dc_req_valid, ic_req_valid};
  assign r_rw     = {dc_req_rw, ic_req_rw};
  assign r_dvalid = {dc_req_data_valid, ic_req_data_valid};
  assign r_addr   = {dc_req_addr, ic_req_addr};
  assign r_bits   = {dc_req_data_bits, ic_req_data_bits};
  assign r_mask   = {dc_req_data_mask, ic_req_data_mask};

  logic gnt, any;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (r_valid),
    .en    (state == S_IDLE),
    .gnt   (gnt),
    .any   (any)
  );

  logic in_req, in_wd, pass_data, req_hs, data_hs, rdy, drdy, rv;

  assign in_req = (state == S_REQ);
  assign in_wd  = (state == S_WDATA);
  // Write data stops being forwarded once it has already been accepted.
  assign pass_data = (in_req && r_rw[owner] && !data_done) || in_wd;

  always_comb begin
    mem_req_valid      = in_req && r_valid[owner];
    mem_req_addr       = (in_req || in_wd) ? r_addr[owner] : '0;
    mem_req_rw         = (in_req || in_wd) ? r_rw[owner] : 1'b0;
    mem_req_data_valid = pass_data && r_dvalid[owner];
    mem_req_data_bits  = pass_data ? r_bits[owner] : '0;
    mem_req_data_mask  = pass_data ? r_mask[owner] : '0;
  end

  assign req_hs  = mem_req_valid && mem_req_ready;
  assign data_hs = mem_req_data_valid && mem_req_data_ready;
  assign rdy     = in_req && mem_req_ready;
  assign drdy    = pass_data && mem_req_data_ready;
  assign rv      = (state == S_RRESP) && mem_resp_valid;

  assign ic_req_ready      = rdy && !owner;
  assign dc_req_ready      = rdy && owner;
  assign ic_req_data_ready = drdy && !owner;
  assign dc_req_data_ready = drdy && owner;
  assign ic_resp_valid     = rv && !owner;
  assign dc_resp_valid     = rv && owner;
  assign ic_resp_data      = reset ? mem_resp_data : '0;
  assign dc_resp_data      = reset ? mem_resp_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      cnt       <= '0;
      data_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          data_done <= 1'b0;
          if (any) begin
            owner <= gnt;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!r_valid[owner]) begin
            state     <= S_IDLE;
            data_done <= 1'b0;
          end else if (req_hs) begin
            if (!r_rw[owner]) begin
              state <= S_RRESP;
              cnt   <= '0;
            end else if (data_done || data_hs) begin
              state     <= S_IDLE;
              data_done <= 1'b0;
            end else begin
              state <= S_WDATA;
            end
          end else if (data_hs) begin
            data_done <= 1'b1;
          end
        end
        S_WDATA: begin
          if (data_hs) state <= S_IDLE;
        end
        S_RRESP: begin
          if (mem_resp_valid) begin
            if (cnt == LAST_BEAT) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
